// File: rtl/seq_divider_8by4_pkg.sv
// Shared constants for the sequential 8-by-4 restoring divider.
// Holds the state encoding, the default operand widths and the iteration counter width.
package seq_divider_8by4_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;
  localparam int CNT_W          = $clog2(DIVIDEND_W_DEF);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/seq_divider_8by4_if.sv
// Operand and result handshake bundle for seq_divider_8by4.
// The master modport is the producer/consumer side; the slave modport is the divider.
interface seq_divider_8by4_if
  import seq_divider_8by4_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider_8by4_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// The subtract is a two's-complement add through a Kogge-Stone prefix carry network.
module restoring_div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   prem,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   prem_next,
  output logic                 q_bit
);

  localparam int W = DIVISOR_W + 1;

  // Returns {carry_out, sum} of a + b + cin using a Kogge-Stone prefix tree.
  function automatic logic [W:0] ks_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin
  );
    logic [W-1:0] h;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] g_nx;
    logic [W-1:0] p_nx;
    h    = a ^ b;
    g    = a & b;
    p    = h;
    g[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < W; d = d * 2) begin
      g_nx = g;
      p_nx = p;
      for (int i = d; i < W; i++) begin
        g_nx[i] = g[i] | (p[i] & g[i-d]);
        p_nx[i] = p[i] & p[i-d];
      end
      g = g_nx;
      p = p_nx;
    end
    ks_add = {g[W-1], h ^ {g[W-2:0], cin}};
  endfunction

  logic [W-1:0] shifted_s;
  logic [W:0]   trial_s;
  logic         no_borrow_s;

  // Trial subtraction; a carry out of a + ~b + 1 means no borrow.
  always_comb begin
    shifted_s   = {prem[DIVISOR_W-1:0], din};
    trial_s     = ks_add(shifted_s, ~{1'b0, divisor}, 1'b1);
    // prem MSB is zero whenever prem < divisor; folding it in keeps the bit correct regardless.
    no_borrow_s = trial_s[W] | prem[DIVISOR_W];
    q_bit       = no_borrow_s;
    if (no_borrow_s) begin
      prem_next = trial_s[W-1:0];
    end else begin
      prem_next = shifted_s;
    end
  end

endmodule

// File: rtl/seq_divider_8by4.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// Valid/ready on both sides; a zero divisor short-circuits straight to a flagged result.
module seq_divider_8by4
  import seq_divider_8by4_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input logic              clk,
  input logic              rst,
  seq_divider_8by4_if.slave bus
);

  localparam int PREM_W = DIVISOR_W + 1;

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [PREM_W-1:0]     prem_r;
  logic [PREM_W-1:0]     prem_next_s;
  logic [DIVIDEND_W-1:0] dvd_r;
  logic [DIVISOR_W-1:0]  dvs_r;
  logic                  q_bit_s;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [DIVIDEND_W-1:0] quo_r;
  logic [DIVISOR_W-1:0]  rem_r;
  logic                  dbz_r;
  logic                  accept_s;
  logic                  release_s;

  restoring_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem      (prem_r),
    .din       (dvd_r[DIVIDEND_W-1]),
    .divisor   (dvs_r),
    .prem_next (prem_next_s),
    .q_bit     (q_bit_s)
  );

  // Handshake qualifiers for both interface sides.
  always_comb begin
    accept_s  = bus.in_valid && in_ready_r;
    release_s = out_valid_r && bus.out_ready;
  end

  // FSM, iteration counter and datapath registers. dvd_r doubles as the quotient
  // shift register: dividend bits leave at the MSB while quotient bits enter at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      prem_r      <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quo_r       <= '0;
      rem_r       <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            dvd_r      <= bus.dividend;
            dvs_r      <= bus.divisor;
            prem_r     <= '0;
            in_ready_r <= 1'b0;
            if (bus.divisor == '0) begin
              quo_r       <= '1;
              rem_r       <= bus.dividend[DIVISOR_W-1:0];
              dbz_r       <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              cnt_r   <= CNT_W'(DIVIDEND_W - 1);
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          prem_r <= prem_next_s;
          dvd_r  <= {dvd_r[DIVIDEND_W-2:0], q_bit_s};
          if (cnt_r == '0) begin
            quo_r       <= {dvd_r[DIVIDEND_W-2:0], q_bit_s};
            rem_r       <= prem_next_s[DIVISOR_W-1:0];
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          if (release_s) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Directed and randomized bench for seq_divider_8by4 against a plain-arithmetic reference.
module tb_seq_divider_8by4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   order [4096];

  seq_divider_8by4_if bus ();

  seq_divider_8by4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: ordinary integer division, saturated all-ones quotient on a zero divisor.
  task automatic check_result(input string tag, input int a, input int b);
    int q;
    int r;
    int d;
    if (b == 0) begin
      q = 255;
      r = a % 16;
      d = 1;
    end else begin
      q = a / b;
      r = a % b;
      d = 0;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_quot"}, 32'(bus.quotient), q);
    check({tag, "_rem"}, 32'(bus.remainder), r);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), d);
  endtask

  // Present operands and return once the accepting edge has passed.
  task automatic issue(input int a, input int b);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 4'(b);
    while (!bus.in_ready && guard < 30) begin
      tick();
      guard++;
    end
    check("in_ready_wait", 32'(guard < 30), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
  endtask

  task automatic wait_out(output int edges, input bit rand_ready);
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int edges;
    bus.out_ready = 1'b1;
    issue(a, b);
    wait_out(edges, 1'b0);
    check({tag, "_latency"}, edges, (b == 0) ? 0 : 8);
    check_result(tag, a, b);
    tick();
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int edges;
    int hold;
    int a;
    int b;
    int tmp;
    int j;
    n_checks      = 0;
    n_pass        = 0;
    clk           = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = 8'd0;
    bus.divisor   = 4'd0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quot", 32'(bus.quotient), 32'd0);
    check("rst_rem", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_op("d200_7", 200, 7);
    run_op("d255_1", 255, 1);
    run_op("d255_15", 255, 15);
    run_op("d0_5", 0, 5);
    run_op("d13_0", 13, 0);

    // Backpressure: result must hold and a second request must be refused.
    bus.out_ready = 1'b0;
    issue(100, 3);
    wait_out(edges, 1'b0);
    check("bp_latency", edges, 8);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 4'd5;
    for (int k = 0; k < 5; k++) begin
      check_result("bp_hold", 100, 3);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_drop", 32'(bus.out_valid), 32'd0);
    check("bp_idle", 32'(bus.in_ready), 32'd1);
    run_op("d50_5", 50, 5);

    // Reset in the 4th CALC cycle discards the operation.
    issue(200, 7);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_quot", 32'(bus.quotient), 32'd0);
    check("mid_rst_rem", 32'(bus.remainder), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("no_stale", 32'(bus.out_valid), 32'd0);
    end
    run_op("d9_2", 9, 2);

    // Every operand pair in shuffled order with random output backpressure.
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j        = int'($urandom_range(0, i));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      a = order[i] >> 4;
      b = order[i] & 15;
      issue(a, b);
      wait_out(edges, 1'b1);
      check("sweep_latency", edges, (b == 0) ? 0 : 8);
      bus.out_ready = 1'b0;
      hold = int'($urandom_range(0, 2));
      repeat (hold) tick();
      check_result("sweep", a, b);
      bus.out_ready = 1'b1;
      tick();
      check("sweep_drop", 32'(bus.out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
